// File: rtl/cpu16_pkg.sv
// Shared types and constants for the 16-bit CPU front end: widths, PC step,
// fetch FSM state encoding and the {pc, instr} prefetch entry.
package cpu16_pkg;

  localparam int INSTR_W = 16;
  localparam int PC_W    = 16;
  localparam logic [PC_W-1:0] PC_INC = 16'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Instructions are halfword aligned, so bit 0 of any target is dropped.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return {pc[PC_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// Fetch-stage bundle: instruction memory req/ack, redirect input and the
// valid/ready instruction output towards decode.
interface ifetch_queue_if;
  import cpu16_pkg::*;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic               ir_valid;
  logic [INSTR_W-1:0] ir;
  logic [PC_W-1:0]    ir_pc;
  logic               ir_ready;

  modport master (
    output imem_req, imem_addr, ir_valid, ir, ir_pc,
    input  imem_ack, imem_rdata, redirect, redirect_pc, ir_ready
  );

  modport slave (
    input  imem_req, imem_addr, ir_valid, ir, ir_pc,
    output imem_ack, imem_rdata, redirect, redirect_pc, ir_ready
  );

endinterface

// File: rtl/ifq_fifo.sv
// Synchronous prefetch FIFO with flush; head reads as zero while empty so the
// storage array itself never needs a reset.
module ifq_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // NOTE: the data array has no reset; stale contents are never observable
  // because rdata is forced to zero whenever the FIFO is empty.
  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign rdata = empty ? '0 : mem[rd_ptr];

  a_no_overflow : assert property (@(posedge clock) disable iff (!reset_n)
    !(push && full && !pop && !flush));

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch stage: one-outstanding-request fetch FSM feeding a prefetch
// FIFO towards decode. Optional combinational bypass: IFQ_BYPASS_EN.
module ifetch_queue
  import cpu16_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
  input logic            clock,
  input logic            reset_n,
  ifetch_queue_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_t    state, state_n;
  logic [PC_W-1:0] fetch_pc, fetch_pc_n;
  logic [PC_W-1:0] drop_pc, drop_pc_n;
  logic [PC_W-1:0] target_pc;
  logic            take, push_fifo, pop_fifo, fifo_full, fifo_empty;
  logic [CW-1:0]   count, count_after;
  fetch_entry_t    head, new_entry;

  assign target_pc   = align_pc(bus.redirect_pc);
  assign take        = (state == WAIT) && bus.imem_ack && !bus.redirect;
  assign count_after = count + CW'(push_fifo) - CW'(pop_fifo);
  assign new_entry   = '{pc: bus.imem_addr, instr: bus.imem_rdata};
  assign pop_fifo    = bus.ir_ready && !fifo_empty && !bus.redirect;

`ifdef IFQ_BYPASS_EN
  logic bypass;
  // An empty queue forwards the returning word straight to decode; it is only
  // stored if decode does not take it this cycle.
  assign bypass       = take && fifo_empty;
  assign push_fifo    = take && !(bypass && bus.ir_ready);
  assign bus.ir_valid = !fifo_empty || bypass;
  assign bus.ir       = bypass ? bus.imem_rdata : head.instr;
  assign bus.ir_pc    = bypass ? bus.imem_addr  : head.pc;
`else
  assign push_fifo    = take;
  assign bus.ir_valid = !fifo_empty;
  assign bus.ir       = head.instr;
  assign bus.ir_pc    = head.pc;
`endif

  assign bus.imem_req  = (state != IDLE);
  assign bus.imem_addr = fetch_pc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      drop_pc  <= RESET_PC;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      drop_pc  <= drop_pc_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    drop_pc_n  = drop_pc;
    unique case (state)
      IDLE: begin
        if (bus.redirect)   fetch_pc_n = target_pc;
        else if (!fifo_full) state_n   = WAIT;
      end
      WAIT: begin
        if (bus.redirect) begin
          if (bus.imem_ack) begin
            fetch_pc_n = target_pc;
          end else begin
            // The request cannot be withdrawn: keep the old address on the bus
            // and remember where to go once it drains.
            drop_pc_n = target_pc;
            state_n   = DROP;
          end
        end else if (bus.imem_ack) begin
          fetch_pc_n = fetch_pc + PC_INC;
          if (count_after >= DEPTH_C) state_n = IDLE;
        end
      end
      DROP: begin
        if (bus.imem_ack) begin
          fetch_pc_n = bus.redirect ? target_pc : drop_pc;
          state_n    = WAIT;
        end else if (bus.redirect) begin
          drop_pc_n = target_pc;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  ifq_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(fetch_entry_t))
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (bus.redirect),
    .push    (push_fifo),
    .wdata   (new_entry),
    .pop     (pop_fifo),
    .rdata   (head),
    .count   (count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: memory model returns mem[a] = a ^ 16'h7000
// after a programmable number of wait cycles.
module tb_ifetch_queue;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  int          mem_wait = 0;
  int          wait_cnt;
  logic        ovr_en   = 1'b0;
  logic [15:0] ovr_data = 16'h0000;

  ifetch_queue_if bus ();

  ifetch_queue #(
    .DEPTH    (4),
    .RESET_PC (16'h0000)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  // Memory model: counts cycles a request has been pending, resets with the DUT.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n)                            wait_cnt <= 0;
    else if (!bus.imem_req || bus.imem_ack)  wait_cnt <= 0;
    else                                     wait_cnt <= wait_cnt + 1;
  end

  assign bus.imem_ack   = bus.imem_req && (wait_cnt >= mem_wait);
  assign bus.imem_rdata = ovr_en ? ovr_data : (bus.imem_addr ^ 16'h7000);

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic do_reset(input int wt, input logic rdy);
    reset_n         = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 16'h0000;
    bus.ir_ready    = rdy;
    mem_wait        = wt;
    ovr_en          = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset(0, 1'b0);
    checks++; if (bus.imem_req !== 1'b0)      begin errors++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
    checks++; if (bus.imem_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h want 0000", bus.imem_addr); end
    checks++; if (bus.ir_valid !== 1'b0)      begin errors++; $display("FAIL reset_ir_valid: got %b want 0", bus.ir_valid); end
    checks++; if (bus.ir !== 16'h0000)        begin errors++; $display("FAIL reset_ir: got %h want 0000", bus.ir); end
    checks++; if (bus.ir_pc !== 16'h0000)     begin errors++; $display("FAIL reset_ir_pc: got %h want 0000", bus.ir_pc); end
    @(negedge clock);
    checks++; if (bus.imem_req !== 1'b1)      begin errors++; $display("FAIL first_req: got %b want 1", bus.imem_req); end
    checks++; if (bus.imem_addr !== 16'h0000) begin errors++; $display("FAIL first_addr: got %h want 0000", bus.imem_addr); end
  endtask

  task automatic test_stream;
    logic [15:0] e;
    do_reset(0, 1'b1);
    @(negedge clock);
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL stream_req: got %b want 1", bus.imem_req); end
    checks++; if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL stream_fill: got %b want 0", bus.ir_valid); end
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      e = 16'(2 * k);
      checks++; if (bus.ir_valid !== 1'b1)          begin errors++; $display("FAIL stream_valid[%0d]: got %b want 1", k, bus.ir_valid); end
      checks++; if (bus.ir_pc !== e)                begin errors++; $display("FAIL stream_pc[%0d]: got %h want %h", k, bus.ir_pc, e); end
      checks++; if (bus.ir !== (e ^ 16'h7000))      begin errors++; $display("FAIL stream_ir[%0d]: got %h want %h", k, bus.ir, e ^ 16'h7000); end
    end
  endtask

  task automatic test_backpressure;
    int   n_acks;
    logic seen;
    logic [15:0] e;
    do_reset(0, 1'b0);
    n_acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (bus.imem_req && bus.imem_ack) n_acks++;
    end
    checks++; if (n_acks !== 4)          begin errors++; $display("FAIL bp_push_count: got %0d want 4", n_acks); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL bp_req_low: got %b want 0", bus.imem_req); end
    bus.ir_ready = 1'b1;
    checks++; if (bus.ir_pc !== 16'h0000) begin errors++; $display("FAIL bp_drain_pc[0]: got %h want 0000", bus.ir_pc); end
    seen = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      e = 16'(2 * i);
      checks++; if (bus.ir_valid !== 1'b1) begin errors++; $display("FAIL bp_drain_valid[%0d]: got %b want 1", i, bus.ir_valid); end
      checks++; if (bus.ir_pc !== e)       begin errors++; $display("FAIL bp_drain_pc[%0d]: got %h want %h", i, bus.ir_pc, e); end
      if (bus.imem_req && !seen) begin
        seen = 1'b1;
        checks++; if (bus.imem_addr !== 16'h0008) begin errors++; $display("FAIL bp_resume_addr: got %h want 0008", bus.imem_addr); end
      end
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL bp_resume: request seen %b want 1", seen); end
  endtask

  task automatic test_redirect_wait;
    logic got;
    do_reset(3, 1'b1);
    repeat (2) @(negedge clock);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0040;
    @(negedge clock);
    bus.redirect = 1'b0;
    checks++; if (bus.imem_req !== 1'b1)      begin errors++; $display("FAIL rw_drop_req: got %b want 1", bus.imem_req); end
    checks++; if (bus.imem_addr !== 16'h0000) begin errors++; $display("FAIL rw_drop_addr: got %h want 0000", bus.imem_addr); end
    @(negedge clock);
    checks++; if (bus.ir_valid !== 1'b0)      begin errors++; $display("FAIL rw_discard: got %b want 0", bus.ir_valid); end
    @(negedge clock);
    checks++; if (bus.imem_addr !== 16'h0040) begin errors++; $display("FAIL rw_new_addr: got %h want 0040", bus.imem_addr); end
    checks++; if (bus.ir_valid !== 1'b0)      begin errors++; $display("FAIL rw_no_stale: got %b want 0", bus.ir_valid); end
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clock);
      got = bus.ir_valid;
    end
    checks++; if (got !== 1'b1)            begin errors++; $display("FAIL rw_timeout: ir_valid %b want 1", got); end
    checks++; if (bus.ir_pc !== 16'h0040)  begin errors++; $display("FAIL rw_first_pc: got %h want 0040", bus.ir_pc); end
    checks++; if (bus.ir !== 16'h7040)     begin errors++; $display("FAIL rw_first_ir: got %h want 7040", bus.ir); end
  endtask

  task automatic test_redirect_ack_pop;
    do_reset(0, 1'b0);
    repeat (3) @(negedge clock);
    checks++; if (bus.ir_valid !== 1'b1)      begin errors++; $display("FAIL rap_pre_valid: got %b want 1", bus.ir_valid); end
    checks++; if (bus.imem_addr !== 16'h0004) begin errors++; $display("FAIL rap_pre_addr: got %h want 0004", bus.imem_addr); end
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0101;
    bus.ir_ready    = 1'b1;
    @(negedge clock);
    bus.redirect = 1'b0;
    checks++; if (bus.ir_valid !== 1'b0)      begin errors++; $display("FAIL rap_flush: got %b want 0", bus.ir_valid); end
    checks++; if (bus.imem_req !== 1'b1)      begin errors++; $display("FAIL rap_req: got %b want 1", bus.imem_req); end
    checks++; if (bus.imem_addr !== 16'h0100) begin errors++; $display("FAIL rap_addr: got %h want 0100", bus.imem_addr); end
    @(negedge clock);
    checks++; if (bus.ir_valid !== 1'b1)      begin errors++; $display("FAIL rap_valid: got %b want 1", bus.ir_valid); end
    checks++; if (bus.ir_pc !== 16'h0100)     begin errors++; $display("FAIL rap_pc: got %h want 0100", bus.ir_pc); end
    checks++; if (bus.ir !== 16'h7100)        begin errors++; $display("FAIL rap_ir: got %h want 7100", bus.ir); end
  endtask

  task automatic test_reset_mid;
    do_reset(3, 1'b0);
    repeat (14) @(negedge clock);
    checks++; if (bus.ir_valid !== 1'b1)      begin errors++; $display("FAIL rm_pre_valid: got %b want 1", bus.ir_valid); end
    checks++; if (bus.imem_req !== 1'b1)      begin errors++; $display("FAIL rm_pre_req: got %b want 1", bus.imem_req); end
    checks++; if (bus.imem_addr !== 16'h0006) begin errors++; $display("FAIL rm_pre_addr: got %h want 0006", bus.imem_addr); end
    reset_n = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b0)      begin errors++; $display("FAIL rm_req: got %b want 0", bus.imem_req); end
    checks++; if (bus.imem_addr !== 16'h0000) begin errors++; $display("FAIL rm_addr: got %h want 0000", bus.imem_addr); end
    checks++; if (bus.ir_valid !== 1'b0)      begin errors++; $display("FAIL rm_ir_valid: got %b want 0", bus.ir_valid); end
    checks++; if (bus.ir !== 16'h0000)        begin errors++; $display("FAIL rm_ir: got %h want 0000", bus.ir); end
    checks++; if (bus.ir_pc !== 16'h0000)     begin errors++; $display("FAIL rm_ir_pc: got %h want 0000", bus.ir_pc); end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checks++; if (bus.imem_req !== 1'b1)      begin errors++; $display("FAIL rm_restart_req: got %b want 1", bus.imem_req); end
    checks++; if (bus.imem_addr !== 16'h0000) begin errors++; $display("FAIL rm_restart_addr: got %h want 0000", bus.imem_addr); end
    checks++; if (bus.ir_valid !== 1'b0)      begin errors++; $display("FAIL rm_restart_valid: got %b want 0", bus.ir_valid); end
  endtask

`ifdef IFQ_BYPASS_EN
  task automatic test_bypass;
    do_reset(0, 1'b1);
    repeat (6) @(negedge clock);
    ovr_en   = 1'b1;
    ovr_data = 16'h7123;
    #1;
    checks++; if (bus.imem_addr !== 16'h000A) begin errors++; $display("FAIL bp_addr: got %h want 000a", bus.imem_addr); end
    checks++; if (bus.ir_valid !== 1'b1)      begin errors++; $display("FAIL byp_valid: got %b want 1", bus.ir_valid); end
    checks++; if (bus.ir !== 16'h7123)        begin errors++; $display("FAIL byp_ir: got %h want 7123", bus.ir); end
    checks++; if (bus.ir_pc !== 16'h000A)     begin errors++; $display("FAIL byp_pc: got %h want 000a", bus.ir_pc); end
    @(posedge clock);
    #1;
    ovr_en = 1'b0;
    checks++; if (dut.count !== 3'd0)         begin errors++; $display("FAIL byp_count: got %0d want 0", dut.count); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef IFQ_BYPASS_EN
    test_bypass();
`else
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_ack_pop();
    test_reset_mid();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
